// File: rtl/mips_enc_pkg.sv
// Shared constants for the MIPS instruction encoder/loader: opcodes, op_sel codes, FSM states.
package mips_enc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SUBI  = 6'h09;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FUNCT_OR = 6'h25;

  localparam logic [2:0] OPS_OR   = 3'd0;
  localparam logic [2:0] OPS_SUBI = 3'd1;
  localparam logic [2:0] OPS_SW   = 3'd2;
  localparam logic [2:0] OPS_BEQ  = 3'd3;
  localparam logic [2:0] OPS_NOP  = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: op_sel + register/immediate fields -> 32-bit MIPS word, plus legality flag.
module instr_field_pack
  import mips_enc_pkg::*;
(
  input  logic [2:0]  opSel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (opSel)
      OPS_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
      OPS_SUBI: word = {OP_SUBI, rs, rt, imm};
      OPS_SW:   word = {OP_SW, rs, rt, imm};
      OPS_BEQ:  word = {OP_BEQ, rs, rt, imm};
      OPS_NOP:  word = 32'h0000_0000;
      // Illegal selects fall back to a NOP word; the top decides whether to write it.
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field bundles into MIPS words and writes them sequentially to instruction memory.
// Optional ENC_CHECK_EN: reject op_sel 5..7 with a one-cycle err pulse instead of writing a NOP.
module instr_encoder_loader
  import mips_enc_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 op_sel,
  input  logic [4:0]                 rs,
  input  logic [4:0]                 rt,
  input  logic [4:0]                 rd,
  input  logic [15:0]                imm,
  input  logic                       clear,
  output logic                       imem_we,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic [31:0]                imem_wdata,
  input  logic                       imem_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
`ifdef ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic [31:0]       packedWord;
  logic              opLegal;
  state_t            state;
  logic              readyQ;
  logic              weQ;
  logic              fullQ;
  logic              errQ;
  logic              pendClr;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       wdataQ;
  logic [CNT_W-1:0]  countQ;
  logic [CNT_W-1:0]  countNext;
  logic              clrNow;
  logic              accept;
  logic              rejectOp;

  instr_field_pack uPack (
    .opSel (op_sel),
    .rs    (rs),
    .rt    (rt),
    .rd    (rd),
    .imm   (imm),
    .word  (packedWord),
    .legal (opLegal)
  );

  // A clear deferred from WRITE acts exactly like a fresh clear once back in IDLE/FULL.
  assign clrNow    = clear | pendClr;
  assign accept    = in_valid & readyQ & ~clrNow;
  assign rejectOp  = CHECK_EN & ~opLegal;
  assign countNext = countQ + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      readyQ  <= 1'b0;
      weQ     <= 1'b0;
      fullQ   <= 1'b0;
      errQ    <= 1'b0;
      pendClr <= 1'b0;
      addrQ   <= BASE;
      wdataQ  <= 32'h0000_0000;
      countQ  <= '0;
    end else begin
      errQ <= 1'b0;
      case (state)
        IDLE: begin
          if (clrNow) begin
            countQ  <= '0;
            addrQ   <= BASE;
            pendClr <= 1'b0;
            readyQ  <= 1'b1;
          end else if (accept) begin
            if (rejectOp) begin
              errQ <= 1'b1;
            end else begin
              wdataQ <= packedWord;
              weQ    <= 1'b1;
              readyQ <= 1'b0;
              state  <= WRITE;
            end
          end else begin
            readyQ <= 1'b1;
          end
        end
        WRITE: begin
          if (clear) pendClr <= 1'b1;
          if (imem_ack) begin
            weQ    <= 1'b0;
            countQ <= countNext;
            addrQ  <= addrQ + ADDR_W'(4);
            if (countNext == DEPTH_CNT) begin
              fullQ <= 1'b1;
              state <= FULL;
            end else begin
              // Hold off new bundles for the cycle in which a pending clear is applied.
              readyQ <= ~(clear | pendClr);
              state  <= IDLE;
            end
          end
        end
        FULL: begin
          if (clrNow) begin
            countQ  <= '0;
            addrQ   <= BASE;
            fullQ   <= 1'b0;
            pendClr <= 1'b0;
            readyQ  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = readyQ;
  assign imem_we    = weQ;
  assign imem_addr  = addrQ;
  assign imem_wdata = wdataQ;
  assign count      = countQ;
  assign full       = fullQ;
  assign err        = errQ;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding table plus stall, full, clear and reset sequences.
module tb_instr_encoder_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_sel;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic              clear;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              err;

  int passCnt  = 0;
  int totalCnt = 0;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm),
    .clear      (clear),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_ack   (imem_ack),
    .count      (count),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    int          ackDly;
    logic [31:0] expWord;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic driveBundle(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t,
                             input logic [4:0] d, input logic [15:0] i);
    op_sel = o; rs = s; rt = t; rd = d; imm = i;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic writeWord(input string name, input logic [2:0] o, input logic [4:0] s,
                           input logic [4:0] t, input logic [4:0] d, input logic [15:0] i,
                           input int ackDly, input logic [31:0] expWord,
                           input logic [ADDR_W-1:0] expAddr);
    waitReady(name);
    driveBundle(o, s, t, d, i);
    check({name, "_we"}, {31'd0, imem_we}, 32'd1);
    check({name, "_wdata"}, imem_wdata, expWord);
    check({name, "_addr"}, {24'd0, imem_addr}, {24'd0, expAddr});
    for (int k = 0; k < ackDly; k++) begin
      @(negedge clk);
      check({name, "_stall_we"}, {31'd0, imem_we}, 32'd1);
      check({name, "_stall_wdata"}, imem_wdata, expWord);
      check({name, "_stall_addr"}, {24'd0, imem_addr}, {24'd0, expAddr});
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check({name, "_we_drop"}, {31'd0, imem_we}, 32'd0);
  endtask

  task automatic clearPulse();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{OPS_OR_C(),   5'd1,  5'd2,  5'd3,  16'h0000, 0, 32'h0022_1825};
    vecs[1] = '{3'd1,         5'd4,  5'd5,  5'd0,  16'h0010, 0, 32'h2485_0010};
    vecs[2] = '{3'd2,         5'd0,  5'd5,  5'd0,  16'h0008, 3, 32'hAC05_0008};
    vecs[3] = '{3'd3,         5'd1,  5'd1,  5'd0,  16'hFFFF, 1, 32'h1021_FFFF};
    vecs[4] = '{3'd4,         5'd31, 5'd31, 5'd31, 16'hFFFF, 0, 32'h0000_0000};
    vecs[5] = '{3'd0,         5'd31, 5'd31, 5'd31, 16'h1234, 2, 32'h03FF_F825};
    vecs[6] = '{3'd1,         5'd0,  5'd0,  5'd7,  16'hABCD, 0, 32'h2400_ABCD};

    rst = 1'b1; in_valid = 1'b0; op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0;
    clear = 1'b0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",    {31'd0, imem_we}, 32'd0);
    check("rst_addr",  {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_full",  {31'd0, full}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    rst = 1'b0;

    // Encoding table, consecutive addresses, assorted ack stalls
    for (int v = 0; v < 7; v++) begin
      writeWord($sformatf("vec%0d", v), vecs[v].op, vecs[v].rs, vecs[v].rt, vecs[v].rd,
                vecs[v].imm, vecs[v].ackDly, vecs[v].expWord, ADDR_W'(4 * v));
      check($sformatf("vec%0d_count", v), {28'd0, count}, v + 1);
    end
    check("tbl_full", {31'd0, full}, 32'd0);

    // clear in IDLE, with a competing in_valid that must be dropped
    waitReady("clr_idle");
    in_valid = 1'b1; op_sel = 3'd0;
    clearPulse();
    in_valid = 1'b0;
    check("clr_idle_count", {28'd0, count}, 32'd0);
    check("clr_idle_addr",  {24'd0, imem_addr}, 32'd0);
    check("clr_idle_we",    {31'd0, imem_we}, 32'd0);

    // Fill to DEPTH, then FULL blocks further bundles until clear
    for (int w = 0; w < DEPTH; w++)
      writeWord($sformatf("fill%0d", w), 3'd3, 5'd1, 5'd1, 5'd0, 16'hFFFF, 0,
                32'h1021_FFFF, ADDR_W'(4 * w));
    check("full_flag",  {31'd0, full}, 32'd1);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    check("full_count", {28'd0, count}, DEPTH);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_no_we", {31'd0, imem_we}, 32'd0);
    end
    in_valid = 1'b0;
    check("full_count_hold", {28'd0, count}, DEPTH);
    clearPulse();
    check("full_clr_count", {28'd0, count}, 32'd0);
    check("full_clr_addr",  {24'd0, imem_addr}, 32'd0);
    check("full_clr_flag",  {31'd0, full}, 32'd0);
    @(negedge clk);
    check("full_clr_ready", {31'd0, in_ready}, 32'd1);

    // clear during WRITE is deferred until the in-flight write completes
    writeWord("pend_a", 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 0, 32'h0022_1825, 8'd0);
    waitReady("pend_b");
    driveBundle(3'd1, 5'd4, 5'd5, 5'd0, 16'h0010);
    check("pend_b_addr", {24'd0, imem_addr}, 32'd4);
    clearPulse();
    check("pend_b_we_held", {31'd0, imem_we}, 32'd1);
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("pend_done_count", {28'd0, count}, 32'd2);
    check("pend_done_addr",  {24'd0, imem_addr}, 32'd8);
    check("pend_done_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("pend_clr_count", {28'd0, count}, 32'd0);
    check("pend_clr_addr",  {24'd0, imem_addr}, 32'd0);

    // Illegal op_sel
    waitReady("illegal");
    driveBundle(3'd6, 5'd9, 5'd9, 5'd9, 16'h5555);
`ifdef ENC_CHECK_EN
    check("illegal_err",   {31'd0, err}, 32'd1);
    check("illegal_no_we", {31'd0, imem_we}, 32'd0);
    @(negedge clk);
    check("illegal_err_pulse", {31'd0, err}, 32'd0);
    check("illegal_count",     {28'd0, count}, 32'd0);
    check("illegal_ready",     {31'd0, in_ready}, 32'd1);
`else
    check("illegal_err",   {31'd0, err}, 32'd0);
    check("illegal_we",    {31'd0, imem_we}, 32'd1);
    check("illegal_wdata", imem_wdata, 32'd0);
    check("illegal_addr",  {24'd0, imem_addr}, 32'd0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("illegal_count", {28'd0, count}, 32'd1);
`endif

    // Asynchronous reset in the middle of a write
    waitReady("rstmid");
    driveBundle(3'd2, 5'd3, 5'd4, 5'd0, 16'h0044);
    check("rstmid_we_before", {31'd0, imem_we}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_we",    {31'd0, imem_we}, 32'd0);
    check("rstmid_ready", {31'd0, in_ready}, 32'd0);
    check("rstmid_addr",  {24'd0, imem_addr}, 32'd0);
    check("rstmid_wdata", imem_wdata, 32'd0);
    check("rstmid_count", {28'd0, count}, 32'd0);
    check("rstmid_full",  {31'd0, full}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    writeWord("after_rst", 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 0, 32'h0022_1825, 8'd0);
    check("after_rst_count", {28'd0, count}, 32'd1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  function automatic logic [2:0] OPS_OR_C();
    return 3'd0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
